// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide sequencer for the Execute stage. It executes
//   MULT, MULTU, DIV and DIVU in 33 cycles: 32 RUN iterations followed by one
//   FIX cycle that applies the sign correction. One shared 33-bit
//   add/subtract datapath serves both operations. The unit also owns the
//   architectural HI/LO registers, which MTHI and MTLO write directly.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   StartE     start an operation with the current operands (IDLE only)
//   MulDivOpE  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcAE      multiplicand/dividend; data for MTHI/MTLO
//   SrcBE      multiplier/divisor
//   HiWriteE   MTHI: HI <= SrcAE (IDLE only)
//   LoWriteE   MTLO: LO <= SrcAE (IDLE only)
//   BusyE      operation in progress (registered)
//   DoneE      one-cycle pulse in the cycle after HI/LO receive a result
//   HiOut      architectural HI
//   LoOut      architectural LO
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             HiWriteE,
  input  logic             LoWriteE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdState_t;

  mdState_t         state_r;
  logic [5:0]       cnt_r;
  logic             isDiv_r;
  logic             signP_r;
  logic             signR_r;
  logic [WIDTH-1:0] bMag_r;
  logic [WIDTH-1:0] origA_r;
  // The accumulator holds the product (multiply) or {remainder, dividend/quotient} (divide).
  logic [WIDTH-1:0] accHi_r;
  logic [WIDTH-1:0] accLo_r;

  logic             signedOp_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   opA_s;
  logic [WIDTH:0]   opB_s;
  logic             sub_s;
  logic [WIDTH+1:0] sumFull_s;
  logic             noBorrow_s;
  logic [2*WIDTH-1:0] prodNeg_s;

  // Two's-complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg32(input logic [WIDTH-1:0] v);
    neg32 = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand: the negated value for negative signed inputs, otherwise the raw value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
    magnitude = (isSigned && v[WIDTH-1]) ? neg32(v) : v;
  endfunction

  assign signedOp_s = ~MulDivOpE[0];

  // Shared add/subtract datapath: shift-add for multiply, trial subtract for divide.
  always_comb begin
    shifted_s = {accHi_r, accLo_r[WIDTH-1]};
    opA_s     = {(WIDTH+1){1'b0}};
    opB_s     = {(WIDTH+1){1'b0}};
    sub_s     = 1'b0;
    if (isDiv_r) begin
      opA_s = shifted_s;
      opB_s = {1'b0, bMag_r};
      sub_s = 1'b1;
    end else begin
      opA_s = {1'b0, accHi_r};
      opB_s = accLo_r[0] ? {1'b0, bMag_r} : {(WIDTH+1){1'b0}};
      sub_s = 1'b0;
    end
    // Subtraction is A + ~B + 1; the carry out is set when the result is non-negative.
    sumFull_s  = {1'b0, opA_s} + {1'b0, opB_s ^ {(WIDTH+1){sub_s}}}
               + {{(WIDTH+1){1'b0}}, sub_s};
    noBorrow_s = sumFull_s[WIDTH+1];
  end

  // 64-bit negate of the product, used for the signed-multiply correction.
  assign prodNeg_s = ~{accHi_r, accLo_r} + {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Sequencer FSM with its datapath registers, HI/LO, and the registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      isDiv_r <= 1'b0;
      signP_r <= 1'b0;
      signR_r <= 1'b0;
      bMag_r  <= {WIDTH{1'b0}};
      origA_r <= {WIDTH{1'b0}};
      accHi_r <= {WIDTH{1'b0}};
      accLo_r <= {WIDTH{1'b0}};
      BusyE   <= 1'b0;
      DoneE   <= 1'b0;
      HiOut   <= {WIDTH{1'b0}};
      LoOut   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          DoneE <= 1'b0;
          if (StartE) begin
            // A start wins over simultaneous MTHI/MTLO.
            isDiv_r <= MulDivOpE[1];
            signP_r <= signedOp_s & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            signR_r <= signedOp_s & SrcAE[WIDTH-1];
            bMag_r  <= magnitude(SrcBE, signedOp_s);
            origA_r <= SrcAE;
            accHi_r <= {WIDTH{1'b0}};
            accLo_r <= magnitude(SrcAE, signedOp_s);
            cnt_r   <= 6'd0;
            BusyE   <= 1'b1;
            state_r <= RUN;
          end else begin
            if (HiWriteE) begin
              HiOut <= SrcAE;
            end else begin
              HiOut <= HiOut;
            end
            if (LoWriteE) begin
              LoOut <= SrcAE;
            end else begin
              LoOut <= LoOut;
            end
          end
        end
        RUN: begin
          if (isDiv_r) begin
            // Restoring divide: keep the difference only when it is non-negative.
            if (noBorrow_s) begin
              accHi_r <= sumFull_s[WIDTH-1:0];
              accLo_r <= {accLo_r[WIDTH-2:0], 1'b1};
            end else begin
              accHi_r <= shifted_s[WIDTH-1:0];
              accLo_r <= {accLo_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            // Right-shift the 65-bit {carry, acc_hi, acc_lo}; the multiplier drains out of acc_lo.
            accHi_r <= sumFull_s[WIDTH:1];
            accLo_r <= {sumFull_s[0], accLo_r[WIDTH-1:1]};
          end
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            state_r <= FIX;
          end else begin
            state_r <= RUN;
          end
        end
        FIX: begin
          if (isDiv_r) begin
            if (bMag_r == {WIDTH{1'b0}}) begin
              LoOut <= {WIDTH{1'b1}};
              HiOut <= origA_r;
            end else begin
              LoOut <= signP_r ? neg32(accLo_r) : accLo_r;
              HiOut <= signR_r ? neg32(accHi_r) : accHi_r;
            end
          end else begin
            {HiOut, LoOut} <= signP_r ? prodNeg_s : {accHi_r, accLo_r};
          end
          BusyE   <= 1'b0;
          DoneE   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          BusyE   <= 1'b0;
          DoneE   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer in the Execute stage, alongside the main ALU. Executes MULT, MULTU, DIV and DIVU over 33 cycles using one shared 33-bit add/subtract datapath, and owns the architectural HI/LO registers. The hazard unit uses BusyE to stall the pipeline. HiOut and LoOut feed the MFHI/MFLO path back into the Execute result mux.

## Interface

- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the parameter fixes internal register sizing.

- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- StartE  input  1  start a multiply/divide with the current operands
- MulDivOpE  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  input  32  operand A (multiplicand/dividend); data source for MTHI/MTLO
- SrcBE  input  32  operand B (multiplier/divisor)
- HiWriteE  input  1  MTHI: HI <= SrcAE
- LoWriteE  input  1  MTLO: LO <= SrcAE
- BusyE  output  1  operation in progress; registered
- DoneE  output  1  one-cycle pulse, high in the cycle after HI/LO receive a result
- HiOut  output  32  architectural HI
- LoOut  output  32  architectural LO

## Operation

- States: IDLE, RUN, FIX. Reset state is IDLE.
- IDLE, StartE=1:
  - latch |A| and |B| (magnitudes for signed ops, raw values for unsigned ops)
  - latch signP = A[31]^B[31] and signR = A[31] (signed ops only; 0 for unsigned)
  - latch the original A
  - clear the 6-bit counter; go to RUN
- IDLE, StartE=0: HiWriteE/LoWriteE update HI/LO. Both may be high together.
- RUN, one iteration per cycle, 32 cycles (counter 0..31), then FIX:
  - Multiply: shift-add into a 64-bit accumulator {acc_hi, acc_lo}.
  - Divide: restoring divide. Each cycle, a 33-bit subtract of the divisor from {rem, next dividend bit}; on a non-negative result, keep the difference and shift in quotient bit 1.
- FIX, one cycle, then IDLE:
  - MULT/MULTU: {HI,LO} <= signP ? -acc : acc (64-bit two's-complement negate).
  - DIV/DIVU: LO <= signP ? -quot : quot; HI <= signR ? -rem : rem.
  - Divisor == 0: LO <= 32'hFFFFFFFF and HI <= original A, for both DIV and DIVU. Latency is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. No trap.
- HiOut/LoOut hold their previous values throughout RUN. Only FIX, MTHI/MTLO or reset change them.
- StartE while BusyE=1 is ignored; there is no queuing, and the hazard unit must stall.
- HiWriteE/LoWriteE while BusyE=1 are ignored.
- StartE together with HiWriteE/LoWriteE in IDLE: the start wins and the writes are dropped.
- MulDivOpE, SrcAE and SrcBE are sampled only at the accepting edge. Later changes do not affect the operation.

## Timing

- Reset (any state, including mid-RUN):
  - next edge: state=IDLE, BusyE=0, DoneE=0, HiOut=0, LoOut=0, counter=0
  - any in-flight result is discarded
- Start accepted at edge k:
  - BusyE=1 from after edge k through edge k+33
  - RUN edges k+1..k+32; FIX edge k+33 writes HI/LO
  - BusyE=0 and DoneE=1 for the cycle after edge k+33
- Back-to-back: a new StartE in the DoneE cycle is accepted at edge k+34.
- MTHI/MTLO take effect one edge after assertion in IDLE.
- DoneE never overlaps BusyE=1.

## Test plan

- MULT A=0xFFFFFFFE (-2), B=3 -> after 33 edges: HI=0xFFFFFFFF, LO=0xFFFFFFFA; BusyE high exactly 33 cycles; one DoneE pulse.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT of the same operands -> HI=0, LO=1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5 after 33 edges; DIV 0xFFFFFFF0/0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF0.
- Mid-operation hazards:
  - Start MULT, then assert StartE, HiWriteE and LoWriteE (SrcAE=0x1234) on cycle 5 -> all ignored; the original result lands at edge k+33.
  - Then MTLO 0x1234 in IDLE -> LO=0x1234 next edge.
- Start DIVU with HI=LO=0xAAAAAAAA preset, assert reset at cycle 10 -> next edge: BusyE=0, HI=LO=0, no DoneE.
- After that reset, a new MULTU 6*7 yields HI=0, LO=42.
